// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

    localparam int AW_DEF    = 16;
    localparam int HW_DEF    = 16;
    // Byte distance between consecutive halfwords.
    localparam int HALF_STEP = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        RD_LO     = 3'd2,
        RD_LO_CAP = 3'd3,
        RD_HI_CAP = 3'd4,
        RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core-side request/response bus of the memory responder.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int HW = HW_DEF
) ();

    logic            req;
    logic            we;
    logic            fetch;
    logic [AW-1:0]   addr;
    logic [HW-1:0]   wd;
    logic [2*HW-1:0] rd;
    logic            ready;

    // Core issues requests and waits for ready.
    modport master (
        output req, we, fetch, addr, wd,
        input  rd, ready
    );

    // Responder accepts requests and returns read data.
    modport slave (
        input  req, we, fetch, addr, wd,
        output rd, ready
    );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves halfword writes, data reads and
// variable-length instruction fetches against a 1-cycle-latency RAM.
module mem_responder
    import mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int HW       = HW_DEF,
    parameter int LONG_BIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [HW-1:0] mem_wdata,
    input  logic [HW-1:0] mem_rdata
);

    state_t            state_q;
    logic [AW-1:0]     a_q;
    logic [HW-1:0]     wd_q;
    logic              fetch_q;
    logic [HW-1:0]     lo_q;
    logic [2*HW-1:0]   rd_q;
    logic              ready_q;

    logic              long_s;
    logic [AW-1:0]     a_next_s;
    logic              unused_addr_bit_s;

    // Only fetches may be extended to a second halfword.
    assign long_s            = fetch_q & mem_rdata[LONG_BIT];
    // Wraps modulo 2^AW by construction of the AW-bit sum.
    assign a_next_s          = a_q + AW'(HALF_STEP);
    // Requests are halfword aligned; the byte-select bit is dropped.
    assign unused_addr_bit_s = bus.addr[0];

    // Request sequencing, data capture and the ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= {AW{1'b0}};
            wd_q    <= {HW{1'b0}};
            fetch_q <= 1'b0;
            lo_q    <= {HW{1'b0}};
            rd_q    <= {(2*HW){1'b0}};
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        a_q     <= {bus.addr[AW-1:1], 1'b0};
                        wd_q    <= bus.wd;
                        fetch_q <= bus.fetch;
                        state_q <= bus.we ? WRITE : RD_LO;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                end
                RD_LO: begin
                    state_q <= RD_LO_CAP;
                end
                RD_LO_CAP: begin
                    lo_q <= mem_rdata;
                    if (long_s) begin
                        state_q <= RD_HI_CAP;
                    end else begin
                        rd_q    <= {{HW{1'b0}}, mem_rdata};
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end
                end
                RD_HI_CAP: begin
                    rd_q    <= {mem_rdata, lo_q};
                    state_q <= RESP;
                    ready_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM address: second halfword only while a long fetch is being extended.
    always_comb begin
        mem_addr = a_q;
        if ((state_q == RD_LO_CAP) && long_s) begin
            mem_addr = a_next_s;
        end else begin
            mem_addr = a_q;
        end
    end

    // Write strobe is suppressed during reset so an aborted write never lands.
    assign mem_we    = (state_q == WRITE) & ~reset;
    assign mem_wdata = wd_q;
    assign bus.rd    = rd_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a behavioural RAM and reference model.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    mem_responder_if #(.AW(16), .HW(16)) bus ();

    mem_responder #(.AW(16), .HW(16), .LONG_BIT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous 16-bit RAM with one-cycle read latency.
    logic [15:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[15:1]] <= mem_wdata;
        ram_rdata <= ram[mem_addr[15:1]];
    end

    // Reference memory, indexed by halfword number.
    logic [15:0] ref_mem [int];
    logic [31:0] exp_hold;

    typedef struct {
        logic        we;
        logic        fetch;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [31:0] exp_rd;   // reads only; writes expect rd held
        int          exp_lat;
        logic [15:0] exp_a2;   // mem_addr in cycle 2 for reads
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request from IDLE; reports rd at ready, latency and mem_addr trace.
    task automatic run_txn(input logic we_v, input logic fetch_v,
                           input logic [15:0] addr_v, input logic [15:0] wd_v,
                           output logic [31:0] rd_v, output int lat_v,
                           output logic [15:0] a1_v, output logic [15:0] a2_v,
                           output int we_cnt_v);
        bus.req = 1'b1; bus.we = we_v; bus.fetch = fetch_v;
        bus.addr = addr_v; bus.wd = wd_v;
        lat_v = 99; we_cnt_v = 0; rd_v = 32'h0; a1_v = 16'h0; a2_v = 16'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) a1_v = mem_addr;
            if (k == 2) a2_v = mem_addr;
            if (mem_we) we_cnt_v++;
            if (bus.ready) begin
                lat_v = k;
                rd_v  = bus.rd;
                break;
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference-model expectation for one request.
    task automatic ref_txn(input logic we_v, input logic fetch_v,
                           input logic [15:0] addr_v, input logic [15:0] wd_v,
                           output logic [31:0] rd_e, output int lat_e);
        int idx;
        logic [15:0] lo, hi;
        idx = int'(addr_v) / 2;
        if (we_v) begin
            ref_mem[idx] = wd_v;
            rd_e  = exp_hold;
            lat_e = 2;
        end else begin
            lo = ref_mem.exists(idx) ? ref_mem[idx] : 16'h0;
            if (fetch_v && lo[0]) begin
                hi = ref_mem.exists((idx + 1) % 32768) ? ref_mem[(idx + 1) % 32768] : 16'h0;
                lat_e = 4;
            end else begin
                hi = 16'h0;
                lat_e = 3;
            end
            rd_e = {hi, lo};
            exp_hold = rd_e;
        end
    endtask

    vec_t        vecs [$];
    logic [31:0] rd_v, rd_e;
    int          lat_v, lat_e, wcnt;
    logic [15:0] a1, a2, ra, rw;
    logic        rwe, rf;

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.fetch = 1'b0;
        bus.addr = 16'h0; bus.wd = 16'h0;
        exp_hold = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", bus.rd, 32'h0);
        chk("reset_ready", {31'h0, bus.ready}, 32'h0);
        chk("reset_we", {31'h0, mem_we}, 32'h0);
        chk("reset_addr", {16'h0, mem_addr}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table: writes preload, reads check assembly, latency and addressing.
        vecs.push_back('{1'b1, 1'b0, 16'h0010, 16'hBEEF, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 32'h0000BEEF, 3, 16'h0010});
        vecs.push_back('{1'b1, 1'b0, 16'h0020, 16'h1234, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b1, 16'h0020, 16'h0000, 32'h00001234, 3, 16'h0020});
        vecs.push_back('{1'b1, 1'b0, 16'h0020, 16'h0041, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0022, 16'hABCD, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b1, 16'h0020, 16'h0000, 32'hABCD0041, 4, 16'h0022});
        vecs.push_back('{1'b1, 1'b0, 16'h0030, 16'h0001, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b0, 16'h0030, 16'h0000, 32'h00000001, 3, 16'h0030});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 16'h0003, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h5555, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h0000, 32'h55550003, 4, 16'h0000});
        vecs.push_back('{1'b1, 1'b0, 16'h0013, 16'h0007, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0014, 16'h9999, 32'h0, 2, 16'h0});
        vecs.push_back('{1'b0, 1'b1, 16'h0013, 16'h0000, 32'h99990007, 4, 16'h0014});

        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].fetch, vecs[i].addr, vecs[i].wd, rd_v, lat_v, a1, a2, wcnt);
            if (!vecs[i].we) exp_hold = vecs[i].exp_rd;
            chk($sformatf("vec%0d_lat", i), lat_v, vecs[i].exp_lat);
            chk($sformatf("vec%0d_rd", i), rd_v, exp_hold);
            chk($sformatf("vec%0d_a1", i), {16'h0, a1}, {16'h0, vecs[i].addr & 16'hFFFE});
            chk($sformatf("vec%0d_wecnt", i), wcnt, vecs[i].we ? 1 : 0);
            if (!vecs[i].we) chk($sformatf("vec%0d_a2", i), {16'h0, a2}, {16'h0, vecs[i].exp_a2});
            chk($sformatf("vec%0d_hold", i), bus.rd, exp_hold);
        end

        // Reset during WRITE: no RAM update, no ready, rd cleared, held req accepted.
        run_txn(1'b1, 1'b0, 16'h0060, 16'h2222, rd_v, lat_v, a1, a2, wcnt);
        bus.req = 1'b1; bus.we = 1'b1; bus.fetch = 1'b0; bus.addr = 16'h0060; bus.wd = 16'h7777;
        @(posedge clk); #1;
        chk("pre_rst_we", {31'h0, mem_we}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_we_gated", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        chk("rst_no_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_rd_clear", bus.rd, 32'h0);
        reset = 1'b0; bus.we = 1'b0;
        lat_v = 99; rd_v = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.ready) begin lat_v = k; rd_v = bus.rd; break; end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_lat", lat_v, 3);
        chk("post_rst_rd", rd_v, 32'h00002222);
        ref_mem[16'h0060 / 2] = 16'h2222;
        exp_hold = 32'h00002222;

        // Known reference contents for every directed address written so far.
        ref_mem[16'h0010 / 2] = 16'hBEEF; ref_mem[16'h0020 / 2] = 16'h0041;
        ref_mem[16'h0022 / 2] = 16'hABCD; ref_mem[16'h0030 / 2] = 16'h0001;
        ref_mem[16'hFFFE / 2] = 16'h0003; ref_mem[16'h0000 / 2] = 16'h5555;
        ref_mem[16'h0012 / 2] = 16'h0007; ref_mem[16'h0014 / 2] = 16'h9999;

        // Preload both windows with random data through the DUT.
        for (int h = 0; h < 64; h++) begin
            ra = 16'(h * 2);
            rw = 16'($urandom);
            ref_txn(1'b1, 1'b0, ra, rw, rd_e, lat_e);
            run_txn(1'b1, 1'b0, ra, rw, rd_v, lat_v, a1, a2, wcnt);
            ra = 16'hFF80 + 16'(h * 2);
            rw = 16'($urandom);
            ref_txn(1'b1, 1'b0, ra, rw, rd_e, lat_e);
            run_txn(1'b1, 1'b0, ra, rw, rd_v, lat_v, a1, a2, wcnt);
        end

        // Random mix of writes, data reads and fetches against the reference.
        for (int n = 0; n < 200; n++) begin
            rwe = ($urandom_range(0, 2) == 0);
            rf  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) ra = 16'($urandom_range(0, 16'h007D));
            else                           ra = 16'($urandom_range(16'hFF80, 16'hFFFF));
            rw = 16'($urandom);
            ref_txn(rwe, rf, ra, rw, rd_e, lat_e);
            run_txn(rwe, rf, ra, rw, rd_v, lat_v, a1, a2, wcnt);
            chk($sformatf("rnd%0d_lat", n), lat_v, lat_e);
            chk($sformatf("rnd%0d_rd", n), rd_v, rd_e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
